// File: rtl/wave_sequencer.sv
// wave_sequencer: phase-count sequencer driving a sine generator with ticked runs, bursts and flush
module wave_sequencer #(
   parameter int DIV_W    = 16,
   parameter int PIPE_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [8:0]       cfg_step,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [7:0]       cfg_burst,
   input  logic             start,
   input  logic             stop,
   output logic [8:0]       count,
   output logic             sample_strobe,
   output logic [7:0]       periods,
   output logic             busy,
   output logic             done
);
   localparam int FL_W = $clog2(PIPE_LAT + 1);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t state, state_n;
   logic [8:0] step_r, step_n, count_n;
   logic [DIV_W-1:0] div_r, div_n, div_cnt, div_cnt_n, div_last;
   logic [7:0] burst_r, burst_n, periods_n, periods_inc;
   logic [FL_W-1:0] fl_cnt, fl_cnt_n;
   logic [PIPE_LAT-1:0] pipe;
   logic [9:0] sum;
   logic hs, tick, wrap;
   assign hs = cfg_valid && cfg_ready && state == IDLE;
   assign div_last = (div_r == '0) ? '0 : div_r - 1'b1;
   assign tick = state == RUN && !stop && div_cnt == div_last;
   assign sum = {1'b0, count} + {1'b0, step_r};
   assign wrap = sum[9];
   assign periods_inc = (periods == 8'hFF) ? periods : periods + 8'd1;
   assign sample_strobe = pipe[PIPE_LAT-1];
   // next-state and next-value logic; stop beats a same-cycle tick
   always_comb begin
      state_n = state;
      step_n = step_r;
      div_n = div_r;
      burst_n = burst_r;
      count_n = count;
      periods_n = periods;
      div_cnt_n = '0;
      fl_cnt_n = '0;
      case (state)
         IDLE: begin
            if (hs) begin
               step_n = cfg_step;
               div_n = cfg_div;
               burst_n = cfg_burst;
            end
            if (start && step_n != '0) begin
               state_n = RUN;
               count_n = '0;
               periods_n = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_n = FLUSH;
               count_n = '0;
            end else if (tick) begin
               count_n = sum[8:0];
               if (wrap) begin
                  periods_n = periods_inc;
                  if (burst_r != '0 && periods_inc == burst_r) begin
                     count_n = '0;
                     state_n = FLUSH;
                  end
               end
            end else div_cnt_n = div_cnt + 1'b1;
         end
         FLUSH: begin
            fl_cnt_n = fl_cnt + 1'b1;
            if (fl_cnt == FL_W'(PIPE_LAT - 1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // state, configuration, outputs and strobe pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         step_r <= 9'd1;
         div_r <= DIV_W'(1);
         burst_r <= '0;
         count <= '0;
         periods <= '0;
         div_cnt <= '0;
         fl_cnt <= '0;
         pipe <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         cfg_ready <= 1'b0;
      end else begin
         state <= state_n;
         step_r <= step_n;
         div_r <= div_n;
         burst_r <= burst_n;
         count <= count_n;
         periods <= periods_n;
         div_cnt <= div_cnt_n;
         fl_cnt <= fl_cnt_n;
         pipe <= (pipe << 1) | PIPE_LAT'(tick);
         busy <= state_n != IDLE;
         done <= state == FLUSH && state_n == IDLE;
         cfg_ready <= state_n == IDLE;
      end
   end
endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: scoreboard bench checking counts, strobe timing and run control
module tb_wave_sequencer;
   logic clk = 0, rst = 1, cfg_valid = 0, cfg_ready, start = 0, stop = 0;
   logic [8:0] cfg_step = 0, count;
   logic [15:0] cfg_div = 0;
   logic [7:0] cfg_burst = 0, periods;
   logic sample_strobe, busy, done;
   int cyc = 0, checks = 0, errors = 0, n, m;
   int sb[$];
   int exp_t1[5] = '{0, 128, 256, 384, 0};
   int exp_t6[5] = '{0, 300, 88, 388, 0};
   wave_sequencer #(.DIV_W(16), .PIPE_LAT(3)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_step(cfg_step), .cfg_div(cfg_div), .cfg_burst(cfg_burst),
      .start(start), .stop(stop), .count(count), .sample_strobe(sample_strobe),
      .periods(periods), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_to(input int t);
      while (cyc < t) step();
   endtask
   task automatic cfg_start(input int s, input int d, input int b);
      cfg_valid = 1;
      cfg_step = 9'(s);
      cfg_div = 16'(d);
      cfg_burst = 8'(b);
      start = 1;
      step();
      cfg_valid = 0;
      start = 0;
   endtask
   // every strobe must match the oldest expected strobe cycle
   always @(negedge clk) begin
      if (!rst && sample_strobe) begin
         if (sb.size() == 0) chk("strobe_unexpected", cyc, -1);
         else chk("strobe_cycle", cyc, sb.pop_front());
      end
   end
   initial begin
      step();
      step();
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_strobe", sample_strobe, 0);
      rst = 0;
      step();
      chk("ready_after_rst", cfg_ready, 1);
      // burst of one period at step 128, div 1
      cfg_start(128, 1, 1);
      n = cyc;
      for (int i = 3; i <= 6; i++) sb.push_back(n + i);
      for (int i = 0; i < 5; i++) begin
         wait_to(n + i);
         chk("t1_count", count, exp_t1[i]);
      end
      chk("t1_busy_flush", busy, 1);
      wait_to(n + 6);
      chk("t1_done_early", done, 0);
      step();
      chk("t1_done", done, 1);
      chk("t1_busy_end", busy, 0);
      chk("t1_periods", periods, 1);
      step();
      chk("t1_done_pulse", done, 0);
      // continuous slow run with full wrap, then stop
      cfg_start(1, 4, 0);
      n = cyc;
      for (int i = 0; i < 512; i++) sb.push_back(n + 6 + 4 * i);
      wait_to(n + 3);
      chk("t2_count_hold", count, 0);
      step();
      chk("t2_count_1", count, 1);
      wait_to(n + 2044);
      chk("t2_count_511", count, 511);
      chk("t2_periods_0", periods, 0);
      wait_to(n + 2048);
      chk("t2_wrap_count", count, 0);
      chk("t2_wrap_periods", periods, 1);
      wait_to(n + 2049);
      stop = 1;
      step();
      stop = 0;
      chk("t2_stop_count", count, 0);
      chk("t2_stop_busy", busy, 1);
      wait_to(n + 2052);
      chk("t2_flush_busy", busy, 1);
      step();
      chk("t2_busy_end", busy, 0);
      chk("t2_done", done, 1);
      step();
      chk("t2_done_pulse", done, 0);
      // div 0 behaves like div 1
      cfg_start(128, 0, 1);
      n = cyc;
      for (int i = 3; i <= 6; i++) sb.push_back(n + i);
      step();
      chk("t3_count_1", count, 128);
      wait_to(n + 3);
      chk("t3_count_3", count, 384);
      wait_to(n + 7);
      chk("t3_done", done, 1);
      // step 0 start is ignored
      cfg_start(0, 1, 0);
      chk("t3_step0_busy", busy, 0);
      step();
      chk("t3_step0_busy2", busy, 0);
      chk("t3_step0_ready", cfg_ready, 1);
      // config offered during run is ignored
      cfg_start(64, 1, 1);
      n = cyc;
      for (int i = 3; i <= 10; i++) sb.push_back(n + i);
      wait_to(n + 1);
      cfg_valid = 1;
      cfg_step = 9'd5;
      step();
      chk("t4_ready_run", cfg_ready, 0);
      chk("t4_count_old_step", count, 128);
      cfg_valid = 0;
      wait_to(n + 7);
      chk("t4_count_7", count, 448);
      step();
      chk("t4_burst_end", count, 0);
      wait_to(n + 11);
      chk("t4_done", done, 1);
      // rerun keeps old step; stop coincides with a tick
      start = 1;
      step();
      start = 0;
      m = cyc;
      sb.push_back(m + 3);
      chk("t4_rerun_count0", count, 0);
      step();
      chk("t4_rerun_step", count, 64);
      stop = 1;
      step();
      stop = 0;
      chk("t4_stop_tick_count", count, 0);
      chk("t4_stop_busy", busy, 1);
      wait_to(m + 5);
      chk("t4_stop_done", done, 1);
      chk("t4_periods", periods, 0);
      // reset mid-run two cycles after a tick
      cfg_start(1, 4, 0);
      n = cyc;
      wait_to(n + 4);
      chk("t5_count", count, 1);
      wait_to(n + 5);
      rst = 1;
      step();
      chk("t5_rst_count", count, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_done", done, 0);
      chk("t5_rst_strobe", sample_strobe, 0);
      rst = 0;
      step();
      chk("t5_no_done", done, 0);
      step();
      step();
      chk("t5_no_done2", done, 0);
      start = 1;
      step();
      start = 0;
      m = cyc;
      sb.push_back(m + 3);
      chk("t5_def_count0", count, 0);
      step();
      chk("t5_def_step_div", count, 1);
      stop = 1;
      step();
      stop = 0;
      chk("t5_def_stop", count, 0);
      wait_to(m + 5);
      chk("t5_def_done", done, 1);
      // step 300 wraps with periods counted, burst of two
      cfg_start(300, 1, 2);
      n = cyc;
      for (int i = 3; i <= 6; i++) sb.push_back(n + i);
      for (int i = 0; i < 5; i++) begin
         wait_to(n + i);
         chk("t6_count", count, exp_t6[i]);
         if (i == 2) chk("t6_periods_1", periods, 1);
      end
      wait_to(n + 7);
      chk("t6_done", done, 1);
      chk("t6_periods_2", periods, 2);
      step();
      step();
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 Parameter: DIV_W, 16, width of the sample-period divider.
REQ-002 Parameter: PIPE_LAT, 3, clock cycles from count change to the matching 9-bit sine sample at the wave generator output.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cfg_valid  in  1  configuration offer.
REQ-006 cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready.
REQ-007 cfg_step  in  9  phase increment per sample tick.
REQ-008 cfg_div  in  DIV_W  clock cycles per sample tick; 0 treated as 1.
REQ-009 cfg_burst  in  8  waveform periods per run; 0 = continuous.
REQ-010 start  in  1  begin a run (level sampled each cycle).
REQ-011 stop  in  1  abort a run.
REQ-012 count  out  9  phase index driven to the sine generator's count input.
REQ-013 sample_strobe  out  1  one-cycle pulse marking a new valid sine sample, delayed PIPE_LAT from the tick.
REQ-014 periods  out  8  completed waveform periods in current run.
REQ-015 busy  out  1  high in RUN and FLUSH.
REQ-016 done  out  1  one-cycle pulse on return to IDLE.

Function
REQ-017 States: IDLE, RUN, FLUSH; registered outputs only.
REQ-018 cfg_ready SHALL be 1 exactly in IDLE; a handshake latches step/div/burst into internal registers; values offered outside IDLE are ignored.
REQ-019 IDLE->RUN when start=1 and latched step!=0; start with step=0 is ignored; count=0, periods=0 and divider cleared on entry.
REQ-020 cfg handshake and start in the same IDLE cycle: new configuration latched and the run uses it from its first tick.
REQ-021 Divider counts 0..max(div,1)-1 in RUN; tick asserted on the terminal value, then divider returns to 0; div=1 gives a tick every cycle.
REQ-022 On tick: count <= (count + step) mod 512; wrap when count + step >= 512 (10-bit sum, bit 9 set).
REQ-023 On wrap: periods increments (saturating at 255); if burst!=0 and incremented value == burst, count <= 0 and RUN->FLUSH instead of keeping the wrapped value.
REQ-024 stop=1 in RUN: RUN->FLUSH next edge, count <= 0, no further ticks; stop has priority over a same-cycle tick; stop in IDLE/FLUSH ignored.
REQ-025 start while busy is ignored.
REQ-026 sample_strobe = tick delayed by a PIPE_LAT-stage shift register; stages keep shifting in FLUSH, so ticks issued before leaving RUN still produce strobes.
REQ-027 FLUSH lasts exactly PIPE_LAT cycles, then ->IDLE with done=1 for one cycle; periods holds its final value until next start.
REQ-028 Continuous mode (burst=0): periods saturates at 255, run ends only by stop.

Reset
REQ-029 rst=1 at any clock edge, in any state: state=IDLE, count=0, periods=0, sample_strobe=0, busy=0, done=0, strobe pipeline cleared, divider=0.
REQ-030 Reset configuration: step=1, div=1, burst=0; cfg_ready=0 during the cycle rst is high, 1 from the first cycle after release.
REQ-031 Reset mid-run SHALL not emit done or any residual sample_strobe.

Verification
REQ-032 Reset release, cfg step=128 div=1 burst=1, start -> count 0,128,256,384 on consecutive cycles, then 0 in FLUSH; 4 strobes, the first 3 cycles after the first tick; done 3 cycles after FLUSH entry; periods=1.
REQ-033 step=1 div=4 burst=0 -> count increments every 4th cycle, 511->0 wrap sets periods=1; stop mid-run -> count=0 next cycle, busy low after 3 FLUSH cycles, done single pulse.
REQ-034 div=0 vs div=1 -> identical tick timing; step=0 + start -> stays IDLE, busy=0.
REQ-035 cfg_valid during RUN with step=5 -> cfg_ready=0, run continues with old step; next run uses old step until a new IDLE handshake.
REQ-036 rst asserted in RUN two cycles after a tick -> no strobe, no done; count=0, cfg restored to step=1 div=1 burst=0.
REQ-037 stop and tick same cycle -> count=0, no new tick strobe; step=300 -> count sequence 0,300,88 with wrap counted.
